// File: rtl/network_pkg.sv
// Shared definitions between the network controller and the flash read responder,
// so both sides agree on word/byte widths and the flash response window.
package network_pkg;

    localparam int BYTE_W          = 8;
    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int MEM_ADDR_W      = ADDR_W + 1;
    localparam int LAT_CNT_W       = 4;
    localparam int LATENCY_MAX_DEF = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO_RD,
        ST_LO_WAIT,
        ST_HI_RD,
        ST_HI_WAIT,
        ST_DONE
    } flash_state_t;

    // Byte address of one half of a 16-bit word; the even byte is the low byte.
    function automatic logic [MEM_ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] word_addr,
                                                        input logic              hi_byte);
        return {word_addr, hi_byte};
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable, enable-gated up counter that wraps at a programmable value and
// flags when it sits on that value.
module flex_counter #(
    parameter int NUM_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/flash_read_responder.sv
// Serves 16-bit flash word reads as two byte beats on an 8-bit wait-stated memory
// bus, caches the last address served and flags fetches that overrun the window.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for a request to an address other than the cached one
//   ST_LO_RD   | one-cycle read strobe for the even (low) byte
//   ST_LO_WAIT | wait states for the low byte; captured on the last one
//   ST_HI_RD   | one-cycle read strobe for the odd (high) byte
//   ST_HI_WAIT | wait states for the high byte; word registered on the last one
//   ST_DONE    | flash_valid strobe, cache updated
module flash_read_responder
    import network_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int LATENCY_MAX = LATENCY_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash_ready,
    input  logic [ADDR_W-1:0]     flash_address,
    output logic [WORD_W-1:0]     flashData_out,
    output logic                  flash_valid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [BYTE_W-1:0]     mem_rdata,
    input  logic                  mem_wait,
    output logic                  late_err
);

    localparam int                 WAIT_CNT_W = 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [LAT_CNT_W-1:0]  LAT_LIM   = LAT_CNT_W'(LATENCY_MAX);
    localparam logic [LAT_CNT_W-1:0]  LAT_SAT   = '1;

    flash_state_t         state;
    flash_state_t         next_state;
    logic [ADDR_W-1:0]    req_addr;
    logic [ADDR_W-1:0]    cache_addr;
    logic                 cache_valid;
    logic [BYTE_W-1:0]    lo_buf;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 request;
    logic                 in_wait;
    logic                 wait_flag;
    logic                 wait_done;

    assign request   = flash_ready && (!cache_valid || (flash_address != cache_addr));
    assign in_wait   = (state == ST_LO_WAIT) || (state == ST_HI_WAIT);
    assign wait_done = wait_flag && !mem_wait;

    flex_counter #(
        .NUM_CNT_BITS(WAIT_CNT_W)
    ) u_wait_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (!in_wait),
        .count_enable (in_wait && !mem_wait),
        .rollover_val (WAIT_LAST),
        .rollover_flag(wait_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (request)   next_state = ST_LO_RD;
            ST_LO_RD:                  next_state = ST_LO_WAIT;
            ST_LO_WAIT: if (wait_done) next_state = ST_HI_RD;
            ST_HI_RD:                  next_state = ST_HI_WAIT;
            ST_HI_WAIT: if (wait_done) next_state = ST_DONE;
            ST_DONE:                   next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd      = 1'b0;
        flash_valid = 1'b0;
        mem_addr    = '0;
        case (state)
            ST_LO_RD: begin
                mem_rd   = 1'b1;
                mem_addr = byte_addr(req_addr, 1'b0);
            end
            ST_LO_WAIT: mem_addr = byte_addr(req_addr, 1'b0);
            ST_HI_RD: begin
                mem_rd   = 1'b1;
                mem_addr = byte_addr(req_addr, 1'b1);
            end
            ST_HI_WAIT: mem_addr = byte_addr(req_addr, 1'b1);
            ST_DONE:    flash_valid = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr      <= '0;
            cache_addr    <= '0;
            cache_valid   <= 1'b0;
            lo_buf        <= '0;
            flashData_out <= '0;
            lat_cnt       <= '0;
            late_err      <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (request) begin
                    req_addr <= flash_address;
                    lat_cnt  <= '0;
                end
            end else begin
                if (lat_cnt != LAT_SAT) begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                // lat_cnt trails the request cycle number by one
                if (lat_cnt >= LAT_LIM) begin
                    late_err <= 1'b1;
                end
            end
            if ((state == ST_LO_WAIT) && wait_done) begin
                lo_buf <= mem_rdata;
            end
            if ((state == ST_HI_WAIT) && wait_done) begin
                flashData_out <= {mem_rdata, lo_buf};
            end
            if (state == ST_DONE) begin
                cache_addr  <= req_addr;
                cache_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder: a byte-memory model answers mem_addr,
// each fetch is timed from its request cycle and its data/bus beats checked.
module tb_flash_read_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flash_ready;
    logic [15:0] flash_address;
    logic [15:0] flashData_out;
    logic        flash_valid;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_wait;
    logic        late_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_cnt = 0;
    logic [16:0] rd_q[$];

    flash_read_responder #(
        .WAIT_CYCLES(2),
        .LATENCY_MAX(11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flash_ready  (flash_ready),
        .flash_address(flash_address),
        .flashData_out(flashData_out),
        .flash_valid  (flash_valid),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_wait     (mem_wait),
        .late_err     (late_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [16:0] a);
        case (a)
            17'h00020: return 8'h34;
            17'h00021: return 8'h12;
            17'h1FFFE: return 8'hCD;
            17'h1FFFF: return 8'hAB;
            default:   return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [15:0] word_at(input logic [15:0] w);
        return {byte_at({w, 1'b1}), byte_at({w, 1'b0})};
    endfunction

    assign mem_rdata = byte_at(mem_addr);

    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (flash_valid) valid_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle the request is presented; lat is the cycle flash_valid is seen.
    task automatic run_fetch(input logic [15:0] a, input int stall,
                             input int chg_cyc, input logic [15:0] chg_addr,
                             input int drop_cyc, output int lat);
        int n;
        @(posedge clk);
        #1;
        rd_q.delete();
        flash_address = a;
        flash_ready   = 1'b1;
        mem_wait      = 1'b0;
        n   = 0;
        lat = -1;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            mem_wait = (n >= 2) && (n < 2 + stall);
            if (n == chg_cyc) flash_address = chg_addr;
            if (n == drop_cyc) flash_ready = 1'b0;
            @(negedge clk);
            if (flash_valid) begin
                lat = n;
                break;
            end
        end
        mem_wait = 1'b0;
    endtask

    task automatic chk_beats(input string tag, input logic [16:0] lo, input logic [16:0] hi);
        chk({tag, "_nrd"}, rd_q.size(), 2);
        chk({tag, "_rd0"}, (rd_q.size() > 0) ? rd_q[0] : 17'h0, lo);
        chk({tag, "_rd1"}, (rd_q.size() > 1) ? rd_q[1] : 17'h0, hi);
    endtask

    initial begin
        int lat;
        int v0;
        rst           = 1'b1;
        flash_ready   = 1'b0;
        flash_address = 16'h0000;
        mem_wait      = 1'b0;
        #12;
        chk("rst_data", flashData_out, 16'h0000);
        chk("rst_valid", flash_valid, 1'b0);
        chk("rst_maddr", mem_addr, 17'h0);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_late", late_err, 1'b0);
        rst = 1'b0;

        run_fetch(16'h0010, 0, -1, 16'h0, -1, lat);
        chk("f1_lat", lat, 7);
        chk("f1_data", flashData_out, 16'h1234);
        chk_beats("f1", 17'h00020, 17'h00021);
        chk("f1_late", late_err, 1'b0);

        @(posedge clk);
        v0 = valid_cnt;
        rd_q.delete();
        repeat (6) @(negedge clk);
        chk("hold_valid", valid_cnt - v0, 0);
        chk("hold_nrd", rd_q.size(), 0);
        chk("hold_data", flashData_out, 16'h1234);

        run_fetch(16'h0011, 0, -1, 16'h0, -1, lat);
        chk("step_lat", lat, 7);
        chk("step_data", flashData_out, word_at(16'h0011));

        run_fetch(16'h0012, 3, -1, 16'h0, -1, lat);
        chk("w3_lat", lat, 10);
        chk("w3_data", flashData_out, word_at(16'h0012));
        @(negedge clk);
        chk("w3_late", late_err, 1'b0);

        run_fetch(16'h0013, 6, -1, 16'h0, -1, lat);
        chk("w6_lat", lat, 13);
        @(negedge clk);
        chk("w6_late", late_err, 1'b1);

        run_fetch(16'h0005, 0, 2, 16'h0006, 4, lat);
        chk("mid_lat", lat, 7);
        chk("mid_data", flashData_out, word_at(16'h0005));
        chk_beats("mid", 17'h0000A, 17'h0000B);
        @(posedge clk);
        rd_q.delete();
        repeat (3) @(negedge clk);
        chk("mid_idle_nrd", rd_q.size(), 0);
        chk("late_sticky", late_err, 1'b1);

        run_fetch(16'h0030, 0, -1, 16'h0, -1, lat);
        chk("c30_lat", lat, 7);
        chk("c30_data", flashData_out, word_at(16'h0030));

        @(posedge clk);
        #1;
        flash_address = 16'h0040;
        flash_ready   = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("hw_maddr", mem_addr, 17'h00081);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_data", flashData_out, 16'h0000);
        chk("arst_maddr", mem_addr, 17'h0);
        chk("arst_rd", mem_rd, 1'b0);
        chk("arst_valid", flash_valid, 1'b0);
        chk("arst_late", late_err, 1'b0);
        flash_ready = 1'b0;
        #1;
        rst = 1'b0;

        run_fetch(16'h0030, 0, -1, 16'h0, -1, lat);
        chk("refetch_lat", lat, 7);
        chk("refetch_data", flashData_out, word_at(16'h0030));
        chk_beats("refetch", 17'h00060, 17'h00061);

        run_fetch(16'hFFFF, 0, -1, 16'h0, -1, lat);
        chk("wrap_lat", lat, 7);
        chk("wrap_data", flashData_out, 16'hABCD);
        chk_beats("wrap", 17'h1FFFE, 17'h1FFFF);
        chk("wrap_late", late_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
